hazard_stall_unit: RTL and testbench
====================================

HAZARD_STALL_UNIT -- requirements
Module: hazard_stall_unit

Interface
REQ-001 SHALL have parameter NSRC, default 2: decode-stage source-register ports.
REQ-002 SHALL have parameter NSTG, default 2: downstream stages checked; index 0 = E, 1 = M, and so on.
REQ-003 SHALL have parameter TW, default 2: width of each tuse/tnew field.
REQ-004 SHALL have parameter MULT_CYC, default 5: mult busy cycles.
REQ-005 SHALL have parameter DIV_CYC, default 10: div busy cycles.
REQ-006 SHALL have parameter PCW, default 32: stall performance counter width.
REQ-007 SHALL have ports as below; one clock; reset is asynchronous and active-low:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low
- d_src  in  NSRC*5  decode source register numbers, packed, port k at [5k+4:5k]
- d_tuse  in  NSRC*TW  cycles until each source is needed
- d_eret  in  1  decode instruction is eret
- d_md_use  in  1  decode instruction uses the HI/LO unit
- stg_dst  in  NSTG*5  destination register per stage
- stg_tnew  in  NSTG*TW  cycles until each stage's result is ready
- stg_valid  in  NSTG  stage holds a real instruction
- stg_epc_wr  in  NSTG  stage holds an mtc0 to EPC
- e_md_start  in  1  mult/div issuing in E this cycle
- e_md_is_div  in  1  the issuing operation is a div
- md_cancel  in  1  exception flush; aborts the busy count
- stall  out  1  freeze F/D, bubble into E
- stall_cause  out  3  one-hot-or-more: [0] data, [1] epc, [2] md
- md_busy  out  1  HI/LO unit occupied
- stall_cnt  out  PCW  count of stalled cycles

Function
REQ-008 SHALL assert data hazard for port k and stage j when all of these hold: d_src[k]!=0, stg_valid[j]=1, stg_dst[j]==d_src[k], and d_tuse[k] < stg_tnew[j] (unsigned).
REQ-009 SHALL set stall_cause[0] to the OR of all data hazards over NSRC x NSTG; this path is purely combinational.
REQ-010 SHALL set stall_cause[1] = d_eret & |(stg_epc_wr & stg_valid).
REQ-011 SHALL set stall_cause[2] = d_md_use & (md_busy | e_md_start).
REQ-012 SHALL drive stall = |stall_cause, with zero cycle latency from inputs.
REQ-013 The busy counter SHALL be ceil(log2(max(MULT_CYC,DIV_CYC)+1)) bits wide; md_busy = (count != 0).
REQ-014 The counter SHALL update each clock edge, highest priority first:
- md_cancel: load 0
- e_md_start: load DIV_CYC if e_md_is_div, else MULT_CYC
- count != 0: decrement
- otherwise: hold 0
REQ-015 e_md_start while busy SHALL reload the counter; no queuing.
REQ-016 md_cancel and e_md_start in the same cycle SHALL leave count = 0.
REQ-017 md_busy SHALL go high the cycle after start and stay high for exactly MULT_CYC or DIV_CYC cycles.
REQ-018 stall_cnt SHALL increment on each clock edge where stall=1 and saturate at all-ones.
REQ-019 Values of d_src, d_tuse, stg_dst and stg_tnew SHALL be ignored where stg_valid=0; X on these fields SHALL NOT propagate to stall.

Reset
REQ-020 reset=0 SHALL immediately clear the busy counter and stall_cnt to 0, giving md_busy=0.
REQ-021 While reset=0, stall and stall_cause SHALL still follow REQ-008 to REQ-011, with md_busy forced to 0.
REQ-022 Reset assertion mid-count SHALL abort the count; after release the counter restarts only on a new e_md_start.
REQ-023 Reset release SHALL take effect on the first clk edge after reset rises.

Structure
REQ-024 A shared package SHALL hold: register index width (5), stall_cause bit indices (CAUSE_DATA=0, CAUSE_EPC=1, CAUSE_MD=2), and the default MULT_CYC/DIV_CYC values.
REQ-025 The busy counter SHALL be a single sub-module, md_busy_counter, exporting md_busy; hazard comparison SHALL be generate loops in the top module.
REQ-026 The block SHALL contain no other state than the busy counter and stall_cnt.

Verification
REQ-027 Data hazard: d_src[0]=8, d_tuse[0]=0; stage 0 valid, dst=8, tnew=1 -> stall=1, stall_cause=3'b001. Change tnew to 0 -> stall=0.
REQ-028 Zero register and invalid stage: d_src[1]=0 matching a stage with dst=0, tnew=2 -> stall=0. Also stage 1 with dst=9, tnew=2, valid=0 and d_src[0]=9 -> stall=0.
REQ-029 EPC: d_eret=1, stg_epc_wr=2'b10 with stg_valid[1]=1 -> stall_cause=3'b010; clear stg_valid[1] -> stall=0.
REQ-030 Multiply/divide: pulse e_md_start with e_md_is_div=1 -> md_busy high exactly 10 cycles; d_md_use=1 throughout -> stall on the start cycle plus those 10 cycles; stall_cnt=11.
REQ-031 Cancel and reset: mult start, md_cancel on cycle 3 -> md_busy=0 next cycle; repeat with reset pulsed low mid-count -> counter and stall_cnt are 0 immediately.
REQ-032 Saturation and parameters: with PCW=4 and 20 stall cycles -> stall_cnt holds 4'hF. With NSRC=3, NSTG=3 -> a hazard on port 2 vs stage 2 is detected.

Source files
------------

// File: rtl/hazard_stall_unit_pkg.sv
// Shared definitions for the decode-stage hazard/stall unit.
//   REG_W        : architectural register index width
//   CAUSE_*      : bit positions inside stall_cause
//   DEF_*_CYC    : default HI/LO unit occupancy for mult and div
//   cnt_width()  : busy counter width able to hold the longer occupancy
package hazard_stall_unit_pkg;

  localparam int REG_W        = 5;
  localparam int CAUSE_W      = 3;
  localparam int CAUSE_DATA   = 0;
  localparam int CAUSE_EPC    = 1;
  localparam int CAUSE_MD     = 2;
  localparam int DEF_MULT_CYC = 5;
  localparam int DEF_DIV_CYC  = 10;

  function automatic int cnt_width(input int a, input int b);
    return $clog2(((a > b) ? a : b) + 1);
  endfunction

endpackage

// File: rtl/hazard_stall_unit_md_busy_counter.sv
// HI/LO unit occupancy counter.
// Ports:
//   clk     rising-edge clock
//   reset   asynchronous active-low reset, clears the count
//   start   mult/div issuing this cycle (reloads, never queues)
//   is_div  issuing operation is a div
//   cancel  exception flush, overrides start
//   busy    count != 0
module md_busy_counter
  import hazard_stall_unit_pkg::*;
#(
  parameter int MULT_CYC = DEF_MULT_CYC,
  parameter int DIV_CYC  = DEF_DIV_CYC
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic is_div,
  input  logic cancel,
  output logic busy
);

  localparam int CW = cnt_width(MULT_CYC, DIV_CYC);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (cancel) begin
      count <= '0;
    end else if (start) begin
      count <= is_div ? CW'(DIV_CYC) : CW'(MULT_CYC);
    end else if (count != '0) begin
      count <= count - CW'(1);
    end
  end

  assign busy = (count != '0);

endmodule

// File: rtl/hazard_stall_unit.sv
// Decode-stage interlock: detects RAW data hazards against downstream
// stages, eret-after-mtc0-EPC ordering, and HI/LO unit occupancy, and
// freezes F/D (bubble into E) while any of them holds.
// Ports:
//   clk, reset            clock, asynchronous active-low reset
//   d_src/d_tuse          decode source registers and when each is needed
//   d_eret, d_md_use      decode is eret / uses HI/LO
//   stg_dst/stg_tnew      per-stage destination and cycles until ready
//   stg_valid, stg_epc_wr per-stage real-instruction and mtc0-EPC flags
//   e_md_start/_is_div    mult/div issuing in E
//   md_cancel             exception flush of the HI/LO unit
//   stall, stall_cause    freeze request and its reasons
//   md_busy               HI/LO unit occupied
//   stall_cnt             saturating count of stalled cycles
module hazard_stall_unit
  import hazard_stall_unit_pkg::*;
#(
  parameter int NSRC     = 2,
  parameter int NSTG     = 2,
  parameter int TW       = 2,
  parameter int MULT_CYC = DEF_MULT_CYC,
  parameter int DIV_CYC  = DEF_DIV_CYC,
  parameter int PCW      = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NSRC*REG_W-1:0] d_src,
  input  logic [NSRC*TW-1:0]    d_tuse,
  input  logic                  d_eret,
  input  logic                  d_md_use,
  input  logic [NSTG*REG_W-1:0] stg_dst,
  input  logic [NSTG*TW-1:0]    stg_tnew,
  input  logic [NSTG-1:0]       stg_valid,
  input  logic [NSTG-1:0]       stg_epc_wr,
  input  logic                  e_md_start,
  input  logic                  e_md_is_div,
  input  logic                  md_cancel,
  output logic                  stall,
  output logic [CAUSE_W-1:0]    stall_cause,
  output logic                  md_busy,
  output logic [PCW-1:0]        stall_cnt
);

  logic [NSRC*NSTG-1:0] hz;

  // stg_valid is evaluated first with && so that unknown fields of an
  // empty stage resolve to 0 instead of leaking X into stall.
  for (genvar k = 0; k < NSRC; k++) begin : g_src
    for (genvar j = 0; j < NSTG; j++) begin : g_stg
      assign hz[k*NSTG+j] = stg_valid[j] &&
                            (d_src[k*REG_W +: REG_W] != '0) &&
                            (stg_dst[j*REG_W +: REG_W] == d_src[k*REG_W +: REG_W]) &&
                            (d_tuse[k*TW +: TW] < stg_tnew[j*TW +: TW]);
    end
  end

  md_busy_counter #(
    .MULT_CYC (MULT_CYC),
    .DIV_CYC  (DIV_CYC)
  ) u_md_busy_counter (
    .clk    (clk),
    .reset  (reset),
    .start  (e_md_start),
    .is_div (e_md_is_div),
    .cancel (md_cancel),
    .busy   (md_busy)
  );

  always_comb begin
    stall_cause             = '0;
    stall_cause[CAUSE_DATA] = |hz;
    stall_cause[CAUSE_EPC]  = d_eret & (|(stg_epc_wr & stg_valid));
    stall_cause[CAUSE_MD]   = d_md_use & (md_busy | e_md_start);
  end

  assign stall = |stall_cause;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + PCW'(1);
    end
  end

endmodule

// File: tb/tb_hazard_stall_unit.sv
module tb_hazard_stall_unit;
  import hazard_stall_unit_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [9:0]  d_src;
  logic [3:0]  d_tuse;
  logic        d_eret, d_md_use;
  logic [9:0]  stg_dst;
  logic [3:0]  stg_tnew;
  logic [1:0]  stg_valid, stg_epc_wr;
  logic        e_md_start, e_md_is_div, md_cancel;
  logic        stall;
  logic [2:0]  stall_cause;
  logic        md_busy;
  logic [31:0] stall_cnt;

  logic [14:0] d_src_w;
  logic [5:0]  d_tuse_w;
  logic        d_eret_w, d_md_use_w;
  logic [14:0] stg_dst_w;
  logic [5:0]  stg_tnew_w;
  logic [2:0]  stg_valid_w, stg_epc_wr_w;
  logic        e_md_start_w, e_md_is_div_w, md_cancel_w;
  logic        stall_w;
  logic [2:0]  stall_cause_w;
  logic        md_busy_w;
  logic [3:0]  stall_cnt_w;

  hazard_stall_unit dut (
    .clk(clk), .reset(reset), .d_src(d_src), .d_tuse(d_tuse),
    .d_eret(d_eret), .d_md_use(d_md_use), .stg_dst(stg_dst),
    .stg_tnew(stg_tnew), .stg_valid(stg_valid), .stg_epc_wr(stg_epc_wr),
    .e_md_start(e_md_start), .e_md_is_div(e_md_is_div), .md_cancel(md_cancel),
    .stall(stall), .stall_cause(stall_cause), .md_busy(md_busy),
    .stall_cnt(stall_cnt)
  );

  hazard_stall_unit #(.NSRC(3), .NSTG(3), .PCW(4)) dut_w (
    .clk(clk), .reset(reset), .d_src(d_src_w), .d_tuse(d_tuse_w),
    .d_eret(d_eret_w), .d_md_use(d_md_use_w), .stg_dst(stg_dst_w),
    .stg_tnew(stg_tnew_w), .stg_valid(stg_valid_w), .stg_epc_wr(stg_epc_wr_w),
    .e_md_start(e_md_start_w), .e_md_is_div(e_md_is_div_w), .md_cancel(md_cancel_w),
    .stall(stall_w), .stall_cause(stall_cause_w), .md_busy(md_busy_w),
    .stall_cnt(stall_cnt_w)
  );

  typedef struct packed {
    logic       stall;
    logic [2:0] cause;
    logic       busy;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   checks = 0;
  int   failures = 0;

  int s0[10], t0[10], s1[10], t1[10], ds0[10], tn0[10], ds1[10], tn1[10], vl[10], ex[10];

  task automatic clear_inputs();
    d_src = '0; d_tuse = '0; d_eret = 0; d_md_use = 0;
    stg_dst = '0; stg_tnew = '0; stg_valid = '0; stg_epc_wr = '0;
    e_md_start = 0; e_md_is_div = 0; md_cancel = 0;
    d_src_w = '0; d_tuse_w = '0; d_eret_w = 0; d_md_use_w = 0;
    stg_dst_w = '0; stg_tnew_w = '0; stg_valid_w = '0; stg_epc_wr_w = '0;
    e_md_start_w = 0; e_md_is_div_w = 0; md_cancel_w = 0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    clear_inputs();
    reset = 1'b0;
    #2 reset = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b0;
    #2;
    sb.push_back({1'b0, 3'b000, 1'b0});
    e = sb.pop_front();
    checks++;
    if ({stall, stall_cause, md_busy} !== e) begin
      failures++;
      $display("FAIL reset_outputs: got stall/cause/busy=%b required %b", {stall, stall_cause, md_busy}, e);
    end
    checks++;
    if (stall_cnt !== 32'd0) begin
      failures++;
      $display("FAIL reset_stall_cnt: got %0d required 0", stall_cnt);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_data_hazard();
    s0  = '{8, 8, 0, 0, 3, 9, 9, 9, 5, 5};
    t0  = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 3};
    s1  = '{0, 0, 8, 8, 0, 0, 0, 0, 0, 0};
    t1  = '{0, 0, 1, 2, 0, 0, 0, 0, 0, 0};
    ds0 = '{8, 8, 0, 0, 0, 0, 0, 0, 5, 5};
    tn0 = '{1, 0, 0, 0, 2, 0, 0, 0, 3, 2};
    ds1 = '{0, 0, 8, 8, 0, 9, 9, 10, 0, 0};
    tn1 = '{0, 0, 2, 2, 0, 2, 2, 2, 0, 0};
    vl  = '{1, 1, 2, 2, 1, 0, 2, 2, 1, 1};
    ex  = '{1, 0, 1, 0, 0, 0, 1, 0, 1, 0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      d_src     = {5'(s1[i]), 5'(s0[i])};
      d_tuse    = {2'(t1[i]), 2'(t0[i])};
      stg_dst   = {5'(ds1[i]), 5'(ds0[i])};
      stg_tnew  = {2'(tn1[i]), 2'(tn0[i])};
      stg_valid = 2'(vl[i]);
      sb.push_back({ex[i] != 0, {2'b00, ex[i] != 0}, 1'b0});
      #1;
      e = sb.pop_front();
      checks++;
      if ({stall, stall_cause, md_busy} !== e) begin
        failures++;
        $display("FAIL data_case%0d: got stall/cause/busy=%b required %b", i, {stall, stall_cause, md_busy}, e);
      end
    end
    // unknown fields in empty stages must not reach stall
    @(negedge clk);
    d_src = {5'd0, 5'd9}; d_tuse = 4'b0000;
    stg_dst = {5'd9, 5'bxxxxx}; stg_tnew = {2'd2, 2'bxx};
    stg_valid = 2'b00;
    sb.push_back({1'b0, 3'b000, 1'b0});
    #1;
    e = sb.pop_front();
    checks++;
    if ({stall, stall_cause, md_busy} !== e) begin
      failures++;
      $display("FAIL data_x_invalid: got stall/cause/busy=%b required %b", {stall, stall_cause, md_busy}, e);
    end
    stg_valid = 2'b10;
    sb.push_back({1'b1, 3'b001, 1'b0});
    #1;
    e = sb.pop_front();
    checks++;
    if ({stall, stall_cause, md_busy} !== e) begin
      failures++;
      $display("FAIL data_x_other_stage: got stall/cause/busy=%b required %b", {stall, stall_cause, md_busy}, e);
    end
    clear_inputs();
  endtask

  task automatic test_epc();
    logic [1:0] wr[4]  = '{2'b10, 2'b10, 2'b01, 2'b01};
    logic [1:0] vv[4]  = '{2'b10, 2'b00, 2'b01, 2'b01};
    logic       er[4]  = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic [2:0] xc[4]  = '{3'b010, 3'b000, 3'b010, 3'b000};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      d_eret = er[i]; stg_epc_wr = wr[i]; stg_valid = vv[i];
      sb.push_back({xc[i] != 3'b000, xc[i], 1'b0});
      #1;
      e = sb.pop_front();
      checks++;
      if ({stall, stall_cause, md_busy} !== e) begin
        failures++;
        $display("FAIL epc_case%0d: got stall/cause/busy=%b required %b", i, {stall, stall_cause, md_busy}, e);
      end
    end
    // epc and data together
    @(negedge clk);
    d_eret = 1; stg_epc_wr = 2'b01; stg_valid = 2'b01;
    d_src = {5'd0, 5'd4}; stg_dst = {5'd0, 5'd4}; stg_tnew = 4'b0001;
    sb.push_back({1'b1, 3'b011, 1'b0});
    #1;
    e = sb.pop_front();
    checks++;
    if ({stall, stall_cause, md_busy} !== e) begin
      failures++;
      $display("FAIL epc_and_data: got stall/cause/busy=%b required %b", {stall, stall_cause, md_busy}, e);
    end
    clear_inputs();
  endtask

  task automatic test_md_div();
    pulse_reset();
    @(negedge clk);
    e_md_start = 1; e_md_is_div = 1; d_md_use = 1;
    sb.push_back({1'b1, 3'b100, 1'b0});
    #1;
    e = sb.pop_front();
    checks++;
    if ({stall, stall_cause, md_busy} !== e) begin
      failures++;
      $display("FAIL div_start: got stall/cause/busy=%b required %b", {stall, stall_cause, md_busy}, e);
    end
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      e_md_start = 0; e_md_is_div = 0;
      sb.push_back({i < 10, {i < 10, 2'b00}, i < 10});
      #1;
      e = sb.pop_front();
      checks++;
      if ({stall, stall_cause, md_busy} !== e) begin
        failures++;
        $display("FAIL div_cycle%0d: got stall/cause/busy=%b required %b", i, {stall, stall_cause, md_busy}, e);
      end
    end
    checks++;
    if (stall_cnt !== 32'd11) begin
      failures++;
      $display("FAIL div_stall_cnt: got %0d required 11", stall_cnt);
    end
    clear_inputs();
  endtask

  task automatic test_md_mult();
    @(negedge clk);
    e_md_start = 1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      e_md_start = 0;
      sb.push_back({1'b0, 3'b000, i < 5});
      #1;
      e = sb.pop_front();
      checks++;
      if ({stall, stall_cause, md_busy} !== e) begin
        failures++;
        $display("FAIL mult_cycle%0d: got stall/cause/busy=%b required %b", i, {stall, stall_cause, md_busy}, e);
      end
    end
    clear_inputs();
  endtask

  task automatic test_cancel();
    @(negedge clk);
    e_md_start = 1;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      e_md_start = 0;
      md_cancel = (i == 3);
      sb.push_back({1'b0, 3'b000, i <= 3});
      #1;
      e = sb.pop_front();
      checks++;
      if ({stall, stall_cause, md_busy} !== e) begin
        failures++;
        $display("FAIL cancel_cycle%0d: got stall/cause/busy=%b required %b", i, {stall, stall_cause, md_busy}, e);
      end
    end
    // cancel wins over a simultaneous start, also while already busy
    @(negedge clk);
    md_cancel = 0; e_md_start = 1;
    @(negedge clk);
    md_cancel = 1; e_md_start = 1; e_md_is_div = 1;
    @(negedge clk);
    md_cancel = 0; e_md_start = 0; e_md_is_div = 0;
    sb.push_back({1'b0, 3'b000, 1'b0});
    #1;
    e = sb.pop_front();
    checks++;
    if ({stall, stall_cause, md_busy} !== e) begin
      failures++;
      $display("FAIL cancel_with_start: got stall/cause/busy=%b required %b", {stall, stall_cause, md_busy}, e);
    end
    clear_inputs();
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    e_md_start = 1;
    @(negedge clk);
    e_md_start = 0;
    @(negedge clk);
    e_md_start = 1; e_md_is_div = 1;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      e_md_start = 0; e_md_is_div = 0;
      sb.push_back({1'b0, 3'b000, i < 10});
      #1;
      e = sb.pop_front();
      checks++;
      if ({stall, stall_cause, md_busy} !== e) begin
        failures++;
        $display("FAIL reload_cycle%0d: got stall/cause/busy=%b required %b", i, {stall, stall_cause, md_busy}, e);
      end
    end
    clear_inputs();
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    e_md_start = 1; e_md_is_div = 1; d_md_use = 1;
    repeat (3) @(negedge clk);
    e_md_start = 0; e_md_is_div = 0;
    #1 reset = 1'b0;
    #1;
    checks++;
    if (md_busy !== 1'b0 || stall_cnt !== 32'd0) begin
      failures++;
      $display("FAIL reset_mid_clear: got busy=%b cnt=%0d required busy=0 cnt=0", md_busy, stall_cnt);
    end
    sb.push_back({1'b0, 3'b000, 1'b0});
    e = sb.pop_front();
    checks++;
    if ({stall, stall_cause, md_busy} !== e) begin
      failures++;
      $display("FAIL reset_mid_md_use: got stall/cause/busy=%b required %b", {stall, stall_cause, md_busy}, e);
    end
    // combinational causes keep working while reset is held
    @(negedge clk);
    e_md_start = 1;
    d_src = {5'd0, 5'd6}; stg_dst = {5'd6, 5'd0}; stg_tnew = 4'b1000; stg_valid = 2'b10;
    sb.push_back({1'b1, 3'b101, 1'b0});
    #1;
    e = sb.pop_front();
    checks++;
    if ({stall, stall_cause, md_busy} !== e) begin
      failures++;
      $display("FAIL reset_held_causes: got stall/cause/busy=%b required %b", {stall, stall_cause, md_busy}, e);
    end
    @(negedge clk);
    checks++;
    if (stall_cnt !== 32'd0 || md_busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_held_state: got busy=%b cnt=%0d required busy=0 cnt=0", md_busy, stall_cnt);
    end
    clear_inputs();
    #1 reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      sb.push_back({1'b0, 3'b000, 1'b0});
      #1;
      e = sb.pop_front();
      checks++;
      if ({stall, stall_cause, md_busy} !== e) begin
        failures++;
        $display("FAIL reset_release_cycle%0d: got stall/cause/busy=%b required %b", i, {stall, stall_cause, md_busy}, e);
      end
    end
  endtask

  task automatic test_params();
    pulse_reset();
    @(negedge clk);
    d_src_w = {5'd7, 10'd0}; d_tuse_w = 6'b000000;
    stg_dst_w = {5'd7, 10'd0}; stg_tnew_w = {2'd3, 4'd0}; stg_valid_w = 3'b100;
    sb.push_back({1'b1, 3'b001, 1'b0});
    #1;
    e = sb.pop_front();
    checks++;
    if ({stall_w, stall_cause_w, md_busy_w} !== e) begin
      failures++;
      $display("FAIL wide_port2_stage2: got stall/cause/busy=%b required %b", {stall_w, stall_cause_w, md_busy_w}, e);
    end
    repeat (10) @(negedge clk);
    #1;
    checks++;
    if (stall_cnt_w !== 4'd10) begin
      failures++;
      $display("FAIL sat_cnt_10: got %0d required 10", stall_cnt_w);
    end
    repeat (10) @(negedge clk);
    #1;
    checks++;
    if (stall_cnt_w !== 4'hF) begin
      failures++;
      $display("FAIL sat_cnt_20: got %0d required 15", stall_cnt_w);
    end
    d_tuse_w = {2'd3, 4'd0};
    sb.push_back({1'b0, 3'b000, 1'b0});
    #1;
    e = sb.pop_front();
    checks++;
    if ({stall_w, stall_cause_w, md_busy_w} !== e) begin
      failures++;
      $display("FAIL wide_tuse_ready: got stall/cause/busy=%b required %b", {stall_w, stall_cause_w, md_busy_w}, e);
    end
    // port 2 against stage 0 checks the other end of the index range
    d_tuse_w = 6'b000000;
    stg_dst_w = {10'd0, 5'd7}; stg_tnew_w = {4'd0, 2'd1}; stg_valid_w = 3'b001;
    sb.push_back({1'b1, 3'b001, 1'b0});
    #1;
    e = sb.pop_front();
    checks++;
    if ({stall_w, stall_cause_w, md_busy_w} !== e) begin
      failures++;
      $display("FAIL wide_port2_stage0: got stall/cause/busy=%b required %b", {stall_w, stall_cause_w, md_busy_w}, e);
    end
    clear_inputs();
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_data_hazard();
    test_epc();
    test_md_div();
    test_md_mult();
    test_cancel();
    test_back_to_back();
    test_reset_mid();
    test_params();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
